// File: rtl/accel_tilt_ctrl.sv
// Tilt-to-ball-control converter: windowed averaging, dead zone with hysteresis,
// 2-bit speed quantisation and 8-way heading for the maze ball bot.
module accel_tilt_ctrl #(
  parameter int unsigned AVG_LOG2  = 3,
  parameter int unsigned DEAD      = 64,
  parameter int unsigned STEP_LOG2 = 7,
  parameter int unsigned HYST      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] x_acc,
  input  logic [11:0] y_acc,
  output logic [7:0]  ctrl_out,
  output logic        ctrl_valid
);

  localparam int unsigned AW = 12 + AVG_LOG2;

  localparam logic signed [15:0] T1 = 16'(DEAD);
  localparam logic signed [15:0] T2 = 16'(DEAD + (1 << STEP_LOG2));
  localparam logic signed [15:0] T3 = 16'(DEAD + (2 << STEP_LOG2));
  localparam logic signed [15:0] H1 = T1 - $signed(16'(HYST));
  localparam logic signed [15:0] H2 = T2 - $signed(16'(HYST));
  localparam logic signed [15:0] H3 = T3 - $signed(16'(HYST));

  typedef enum logic [1:0] {ACCUM, COMPUTE, UPDATE} state_t;

  state_t state, state_nxt;
  logic   compute_en, update_en;

  logic [AVG_LOG2-1:0]   count;
  logic signed [AW-1:0]  x_sum, y_sum, x_ext, y_ext, x_total, y_total;
  logic                  take, window_done;
  logic [11:0]           x_avg, y_avg;

  logic [11:0] x_mag_c, y_mag_c, x_mag, y_mag;
  logic [1:0]  x_lvl, y_lvl;
  logic        x_neg, y_neg;

  logic [1:0]  x_speed, y_speed, x_new, y_new;
  logic        moving, moving_new;
  logic [2:0]  dir, dir_new;

  function automatic logic [1:0] level_of(input logic [11:0] mag);
    logic signed [15:0] m;
    m = $signed({4'b0, mag});
    if (m >= T3)      level_of = 2'd3;
    else if (m >= T2) level_of = 2'd2;
    else if (m >= T1) level_of = 2'd1;
    else              level_of = 2'd0;
  endfunction

  function automatic logic [1:0] next_speed(input logic [1:0] lvl, input logic [1:0] cur,
                                            input logic [11:0] mag);
    logic signed [15:0] m;
    logic signed [15:0] hold;
    m = $signed({4'b0, mag});
    case (cur)
      2'd1:    hold = H1;
      2'd2:    hold = H2;
      default: hold = H3;
    endcase
    if (lvl < cur && m >= hold) next_speed = cur;
    else                        next_speed = lvl;
  endfunction

  assign take        = enable && sample_valid;
  assign window_done = take && (count == '1);
  assign x_ext       = {{AVG_LOG2{x_acc[11]}}, x_acc};
  assign y_ext       = {{AVG_LOG2{y_acc[11]}}, y_acc};
  assign x_total     = x_sum + x_ext;
  assign y_total     = y_sum + y_ext;

  // Accumulation runs in every state so samples arriving during COMPUTE/UPDATE
  // land in the next window; the snapshot keeps only the shifted (averaged) bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      x_sum <= '0;
      y_sum <= '0;
      x_avg <= '0;
      y_avg <= '0;
    end else if (!enable) begin
      count <= '0;
      x_sum <= '0;
      y_sum <= '0;
    end else if (take) begin
      if (window_done) begin
        x_avg <= x_total[AW-1:AVG_LOG2];
        y_avg <= y_total[AW-1:AVG_LOG2];
        x_sum <= '0;
        y_sum <= '0;
        count <= '0;
      end else begin
        x_sum <= x_total;
        y_sum <= y_total;
        count <= count + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (window_done) state_nxt = COMPUTE;
      COMPUTE: state_nxt = UPDATE;
      UPDATE:  state_nxt = window_done ? COMPUTE : ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (!enable) state_nxt = ACCUM;
  end

  always_comb begin
    compute_en = (state == COMPUTE);
    update_en  = (state == UPDATE);
  end

  assign x_mag_c = x_avg[11] ? (~x_avg + 12'd1) : x_avg;
  assign y_mag_c = y_avg[11] ? (~y_avg + 12'd1) : y_avg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_mag <= '0;
      y_mag <= '0;
      x_lvl <= '0;
      y_lvl <= '0;
      x_neg <= 1'b0;
      y_neg <= 1'b0;
    end else if (compute_en) begin
      x_mag <= x_mag_c;
      y_mag <= y_mag_c;
      x_lvl <= level_of(x_mag_c);
      y_lvl <= level_of(y_mag_c);
      x_neg <= x_avg[11];
      y_neg <= y_avg[11];
    end
  end

  always_comb begin
    x_new      = next_speed(x_lvl, x_speed, x_mag);
    y_new      = next_speed(y_lvl, y_speed, y_mag);
    moving_new = (x_new != 2'd0) || (y_new != 2'd0);
    dir_new    = dir;
    case ({x_new != 2'd0, y_new != 2'd0})
      2'b01:   dir_new = y_neg ? 3'd4 : 3'd0;
      2'b10:   dir_new = x_neg ? 3'd6 : 3'd2;
      2'b11: begin
        case ({x_neg, y_neg})
          2'b00:   dir_new = 3'd1;
          2'b01:   dir_new = 3'd3;
          2'b11:   dir_new = 3'd5;
          default: dir_new = 3'd7;
        endcase
      end
      default: dir_new = dir;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_speed    <= '0;
      y_speed    <= '0;
      moving     <= 1'b0;
      dir        <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (!enable) begin
        x_speed <= '0;
        y_speed <= '0;
        moving  <= 1'b0;
      end else if (update_en) begin
        x_speed    <= x_new;
        y_speed    <= y_new;
        moving     <= moving_new;
        dir        <= dir_new;
        ctrl_valid <= 1'b1;
      end
    end
  end

  assign ctrl_out = {y_speed, x_speed, moving, dir};

endmodule

// File: tb/tb_accel_tilt_ctrl.sv
// Scoreboard bench for accel_tilt_ctrl: stimulus queues expected bytes and
// output cycles, a negedge monitor pops and checks each ctrl_valid pulse.
module tb_accel_tilt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [11:0] x_acc;
  logic [11:0] y_acc;
  logic [7:0]  ctrl_out;
  logic        ctrl_valid;

  accel_tilt_ctrl #(
    .AVG_LOG2(3),
    .DEAD(64),
    .STEP_LOG2(7),
    .HYST(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_valid(sample_valid),
    .x_acc(x_acc),
    .y_acc(y_acc),
    .ctrl_out(ctrl_out),
    .ctrl_valid(ctrl_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    int unsigned c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ctrl_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && ctrl_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ctrl_valid got=%h at cyc=%0d, required no pulse", ctrl_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (ctrl_out !== e.b || cyc != e.c) begin
          failures++;
          $display("FAIL ctrl_byte got=%h@%0d required=%h@%0d", ctrl_out, cyc, e.b, e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic sample(input int x, input int y);
    @(negedge clk);
    sample_valid = 1'b1;
    x_acc = 12'(x);
    y_acc = 12'(y);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  // Output appears on the 2nd edge after the capturing edge (cyc+1).
  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{b: b, c: cyc + 3});
  endtask

  task automatic window(input int x, input int y, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sample(x, y);
      if (i == 7) expect_byte(b);
      idle(1);
    end
    idle(3);
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b1;
    sample_valid = 1'b0;
    x_acc = '0;
    y_acc = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_out", ctrl_out, 8'h00);
    check("reset_ctrl_valid", {7'b0, ctrl_valid}, 8'h00);
    rst = 1'b1;
    idle(2);

    window(400, 0, 8'h3A);
    window(-100, 200, 8'h9F);
    window(-2048, -2048, 8'hFD);

    for (int i = 0; i < 8; i++) begin
      sample((i < 4) ? 2047 : -2048, 0);
      if (i == 7) expect_byte(8'h05);
      idle(1);
    end
    idle(3);

    window(200, 0, 8'h2A);
    window(180, 0, 8'h2A);
    window(170, 0, 8'h1A);
    window(40, 0, 8'h02);

    window(400, 0, 8'h3A);
    for (int i = 0; i < 5; i++) begin
      sample(400, 0);
      idle(1);
    end
    enable = 1'b0;
    @(negedge clk);
    check("enable_low_ctrl_out", ctrl_out, 8'h02);
    check("enable_low_ctrl_valid", {7'b0, ctrl_valid}, 8'h00);
    for (int i = 0; i < 4; i++) sample(400, 400);
    idle(2);
    check("enable_low_hold", ctrl_out, 8'h02);
    enable = 1'b1;
    window(0, -300, 8'h8C);

    for (int i = 0; i < 16; i++) begin
      if (i < 8) sample(400, 400);
      else       sample(-200, 0);
      if (i == 7)  expect_byte(8'hF9);
      if (i == 15) expect_byte(8'h2E);
    end
    idle(5);
    check("b2b_final_hold", ctrl_out, 8'h2E);

    for (int i = 0; i < 5; i++) sample(300, 300);
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_ctrl_out", ctrl_out, 8'h00);
    check("async_reset_ctrl_valid", {7'b0, ctrl_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    window(-400, 400, 8'hFF);

    idle(6);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
